// File: rtl/fibonacci_lfsr_20_checker.sv
// Receiver-side checker for the x^20 + x^17 + 1 Fibonacci PRBS: self-synchronises,
// flywheels its own prediction once locked, and counts bit errors.
module fibonacci_lfsr_20_checker #(
   parameter int LOCK_MATCHES = 20,
   parameter int LOSS_ERRS    = 4,
   parameter int ERR_WIDTH    = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 in_valid,
   input  logic                 in_bit,
   input  logic                 clear_errs,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic [1:0]           sync_state
);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_MATCHES - 1);
   localparam logic [7:0] LOSS_LAST = 8'(LOSS_ERRS - 1);
   localparam logic [4:0] FILL_LAST = 5'd19;

   state_t                state, state_nxt;
   logic [19:0]           hist, hist_nxt, hist_rx;
   logic [4:0]            fill_cnt, fill_nxt;
   logic [7:0]            match_cnt, match_nxt;
   logic [7:0]            miss_cnt, miss_nxt;
   logic [ERR_WIDTH-1:0]  err_nxt;
   logic                  pred;
   logic                  miss_hit;

   // Prediction of the next bit from y[n-20] ^ y[n-17].
   assign pred    = hist[19] ^ hist[16];
   assign hist_rx = {hist[18:0], in_bit};

   always_comb begin
      state_nxt = state;
      hist_nxt  = hist;
      fill_nxt  = fill_cnt;
      match_nxt = match_cnt;
      miss_nxt  = miss_cnt;
      miss_hit  = 1'b0;
      if (in_valid) begin
         case (state)
            FILL: begin
               hist_nxt = hist_rx;
               if (fill_cnt == FILL_LAST) begin
                  // All-zero history is a dead state for this PRBS; refill instead.
                  fill_nxt = 5'd0;
                  if (hist_rx != 20'd0) state_nxt = VERIFY;
               end else begin
                  fill_nxt = fill_cnt + 5'd1;
               end
            end
            VERIFY: begin
               hist_nxt = hist_rx;
               if (in_bit == pred) begin
                  if (match_cnt == LOCK_LAST) begin
                     state_nxt = LOCKED;
                     match_nxt = 8'd0;
                  end else begin
                     match_nxt = match_cnt + 8'd1;
                  end
               end else begin
                  state_nxt = FILL;
                  fill_nxt  = 5'd0;
                  match_nxt = 8'd0;
               end
            end
            LOCKED: begin
               // Flywheel on the prediction so a corrupted bit is counted once only.
               hist_nxt = {hist[18:0], pred};
               if (in_bit != pred) begin
                  miss_hit = 1'b1;
                  if (miss_cnt == LOSS_LAST) begin
                     state_nxt = FILL;
                     miss_nxt  = 8'd0;
                     fill_nxt  = 5'd0;
                     match_nxt = 8'd0;
                  end else begin
                     miss_nxt = miss_cnt + 8'd1;
                  end
               end else begin
                  miss_nxt = 8'd0;
               end
            end
            default: begin
               state_nxt = FILL;
               fill_nxt  = 5'd0;
               match_nxt = 8'd0;
               miss_nxt  = 8'd0;
            end
         endcase
      end
   end

   // Clear takes effect first, then a same-cycle mismatch is added on top.
   always_comb begin
      err_nxt = err_count;
      if (clear_errs)
         err_nxt = miss_hit ? ERR_WIDTH'(1) : '0;
      else if (miss_hit && (err_count != {ERR_WIDTH{1'b1}}))
         err_nxt = err_count + ERR_WIDTH'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= FILL;
         hist      <= 20'd0;
         fill_cnt  <= 5'd0;
         match_cnt <= 8'd0;
         miss_cnt  <= 8'd0;
         err_count <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         hist      <= hist_nxt;
         fill_cnt  <= fill_nxt;
         match_cnt <= match_nxt;
         miss_cnt  <= miss_nxt;
         err_count <= err_nxt;
         locked    <= (state_nxt == LOCKED);
         err_pulse <= miss_hit;
      end
   end

   assign sync_state = state;

endmodule
